// File: rtl/mc_ctrl_pkg.sv
// rtl/mc_ctrl_pkg.sv - opcode, state and datapath-select code constants for the main control FSM (ILLEGAL_TRAP_EN adds TRAP)
package mc_ctrl_pkg;

    // Opcode field values (IR[31:26]) of the supported instruction subset
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    // alu_op codes
    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    // alu_src_b codes
    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    // pc_source codes
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // State encoding is visible on state_o, so the values are fixed
`ifdef ILLEGAL_TRAP_EN
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_R_EXE    = 4'd6,
        S_R_WB     = 4'd7,
        S_BEQ      = 4'd8,
        S_JMP      = 4'd9,
        S_ADDI_EXE = 4'd10,
        S_ADDI_WB  = 4'd11,
        S_TRAP     = 4'd12
    } state_t;
`else
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_R_EXE    = 4'd6,
        S_R_WB     = 4'd7,
        S_BEQ      = 4'd8,
        S_JMP      = 4'd9,
        S_ADDI_EXE = 4'd10,
        S_ADDI_WB  = 4'd11
    } state_t;
`endif

    // States that wait on the memory handshake
    function automatic logic is_mem_state(input state_t s);
        return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
    endfunction

endpackage

// File: rtl/mc_wait_counter.sv
// rtl/mc_wait_counter.sv - saturating memory-wait counter with a one-cycle timeout pulse
module mc_wait_counter #(
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic waiting,
    output logic mem_timeout
);

    localparam int CNT_W = $clog2(MEM_WAIT_MAX + 1);

    logic [CNT_W-1:0] count;

    // Count consecutive wait cycles; pulse once as the count lands on the limit, then saturate
    always_ff @(posedge clk) begin
        if (reset) begin
            count       <= '0;
            mem_timeout <= 1'b0;
        end else if (waiting) begin
            mem_timeout <= (count == CNT_W'(MEM_WAIT_MAX - 1));
            if (count != CNT_W'(MEM_WAIT_MAX)) begin
                count <= count + CNT_W'(1);
            end
        end else begin
            count       <= '0;
            mem_timeout <= 1'b0;
        end
    end

endmodule

// File: rtl/mc_main_control.sv
// rtl/mc_main_control.sv - multi-cycle CPU main control FSM (optional ILLEGAL_TRAP_EN traps unknown opcodes)
module mc_main_control
    import mc_ctrl_pkg::*;
#(
    parameter int OP_W         = 6,
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [OP_W-1:0] opcode,
    input  logic            mem_ready,
    output logic            pc_write,
    output logic            pc_write_cond,
    output logic            i_or_d,
    output logic            mem_read,
    output logic            mem_write,
    output logic            ir_write,
    output logic            mem_to_reg,
    output logic [1:0]      pc_source,
    output logic [1:0]      alu_op,
    output logic            alu_src_a,
    output logic [1:0]      alu_src_b,
    output logic            reg_write,
    output logic            reg_dst,
    output logic            mem_timeout,
    output logic [3:0]      state_o
);

    state_t          state;
    state_t          state_nxt;
    state_t          dec_state;
    logic [OP_W-1:0] op_q;
    logic            waiting;

    // State register; the opcode is captured in DECODE so MEM_ADDR can pick read vs write
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_FETCH;
            op_q  <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_DECODE) begin
                op_q <= opcode;
            end
        end
    end

    // Next-state logic and Moore output decode (reset forces the FETCH view with strobes off)
    always_comb begin
        state_nxt     = state;
        dec_state     = reset ? S_FETCH : state;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        pc_source     = PCSRC_ALU;
        alu_op        = ALU_ADD;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_B;
        reg_write     = 1'b0;
        reg_dst       = 1'b0;

        case (state)
            S_FETCH:    if (mem_ready) state_nxt = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_W'(OP_LW),
                    OP_W'(OP_SW):     state_nxt = S_MEM_ADDR;
                    OP_W'(OP_RTYPE):  state_nxt = S_R_EXE;
                    OP_W'(OP_BEQ):    state_nxt = S_BEQ;
                    OP_W'(OP_J):      state_nxt = S_JMP;
                    OP_W'(OP_ADDI):   state_nxt = S_ADDI_EXE;
`ifdef ILLEGAL_TRAP_EN
                    default:          state_nxt = S_TRAP;
`else
                    default:          state_nxt = S_FETCH;
`endif
                endcase
            end
            S_MEM_ADDR: state_nxt = (op_q == OP_W'(OP_LW)) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   if (mem_ready) state_nxt = S_MEM_WB;
            S_MEM_WR:   if (mem_ready) state_nxt = S_FETCH;
            S_R_EXE:    state_nxt = S_R_WB;
            S_ADDI_EXE: state_nxt = S_ADDI_WB;
`ifdef ILLEGAL_TRAP_EN
            S_TRAP:     state_nxt = S_TRAP;
`endif
            default:    state_nxt = S_FETCH;
        endcase

        case (dec_state)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                alu_op    = ALU_ADD;
                pc_source = PCSRC_ALU;
                ir_write  = mem_ready & ~reset;
                pc_write  = mem_ready & ~reset;
            end
            S_DECODE: begin
                alu_src_b = SRCB_IMM_SH;
                alu_op    = ALU_ADD;
            end
            S_MEM_ADDR, S_ADDI_EXE: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                alu_op    = ALU_ADD;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEM_WR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
            end
            S_R_EXE: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_B;
                alu_op    = ALU_FUNCT;
            end
            S_R_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_BEQ: begin
                alu_src_a     = 1'b1;
                alu_src_b     = SRCB_B;
                alu_op        = ALU_SUB;
                pc_write_cond = 1'b1;
                pc_source     = PCSRC_ALUOUT;
            end
            S_JMP: begin
                pc_write  = 1'b1;
                pc_source = PCSRC_JUMP;
            end
            S_ADDI_WB:  reg_write = 1'b1;
            default: ;
        endcase
    end

    assign waiting = is_mem_state(state) & ~mem_ready;
    assign state_o = 4'(state);

    mc_wait_counter #(
        .MEM_WAIT_MAX (MEM_WAIT_MAX)
    ) u_wait_counter (
        .clk         (clk),
        .reset       (reset),
        .waiting     (waiting),
        .mem_timeout (mem_timeout)
    );

endmodule

// File: tb/tb_mc_main_control.sv
// tb/tb_mc_main_control.sv - self-checking bench for mc_main_control against an instruction-level plan model
module tb_mc_main_control;

    localparam logic [5:0] T_R    = 6'b000000;
    localparam logic [5:0] T_LW   = 6'b100011;
    localparam logic [5:0] T_SW   = 6'b101011;
    localparam logic [5:0] T_BEQ  = 6'b000100;
    localparam logic [5:0] T_J    = 6'b000010;
    localparam logic [5:0] T_ADDI = 6'b001000;
    localparam logic [5:0] T_BAD  = 6'b111111;
    localparam int         WAIT_LIMIT = 15;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  opcode;
    logic        mem_ready;
    logic        pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg;
    logic [1:0]  pc_source, alu_op, alu_src_b;
    logic        alu_src_a, reg_write, reg_dst, mem_timeout;
    logic [3:0]  state_o;
    logic [15:0] outs;

    int   checks = 0;
    int   errors = 0;
    int   waits_done = 0;
    logic tmo_due = 1'b0;

    typedef struct packed {
        logic [3:0] st;
        logic       rdy;
        logic [5:0] op;
    } step_t;

    step_t plan[$];

    always #5 clk = ~clk;

    mc_main_control #(
        .OP_W         (6),
        .MEM_WAIT_MAX (WAIT_LIMIT)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .opcode        (opcode),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .i_or_d        (i_or_d),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .mem_to_reg    (mem_to_reg),
        .pc_source     (pc_source),
        .alu_op        (alu_op),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .reg_write     (reg_write),
        .reg_dst       (reg_dst),
        .mem_timeout   (mem_timeout),
        .state_o       (state_o)
    );

    assign outs = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg,
                   pc_source, alu_op, alu_src_a, alu_src_b, reg_write, reg_dst};

    // Control word expected in a given state, straight from the per-state output table
    function automatic logic [15:0] exp_out(input int st, input logic rdy);
        logic       pw, pwc, iod, mr, mw, irw, m2r, asa, rw, rd;
        logic [1:0] pcs, aop, asb;
        {pw, pwc, iod, mr, mw, irw, m2r, asa, rw, rd} = '0;
        pcs = 2'b00; aop = 2'b00; asb = 2'b00;
        case (st)
            0:  begin mr = 1'b1; asb = 2'b01; irw = rdy; pw = rdy; end
            1:  asb = 2'b11;
            2:  begin asa = 1'b1; asb = 2'b10; end
            3:  begin mr = 1'b1; iod = 1'b1; end
            4:  begin rw = 1'b1; m2r = 1'b1; end
            5:  begin mw = 1'b1; iod = 1'b1; end
            6:  begin asa = 1'b1; aop = 2'b10; end
            7:  begin rw = 1'b1; rd = 1'b1; end
            8:  begin asa = 1'b1; aop = 2'b01; pwc = 1'b1; pcs = 2'b01; end
            9:  begin pw = 1'b1; pcs = 2'b10; end
            10: begin asa = 1'b1; asb = 2'b10; end
            11: rw = 1'b1;
            default: ;
        endcase
        return {pw, pwc, iod, mr, mw, irw, m2r, pcs, aop, asa, asb, rw, rd};
    endfunction

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic add(input int st, input logic rdy, input logic [5:0] op);
        step_t s;
        s.st  = 4'(st);
        s.rdy = rdy;
        s.op  = op;
        plan.push_back(s);
    endtask

    // Expand one instruction into its expected per-cycle state walk
    task automatic plan_instr(input logic [5:0] op, input int wf, input int wm);
        for (int i = 0; i < wf; i++) add(0, 1'b0, op);
        add(0, 1'b1, op);
        add(1, rbit(), op);
        case (op)
            T_R:    begin add(6, rbit(), op); add(7, rbit(), op); end
            T_ADDI: begin add(10, rbit(), op); add(11, rbit(), op); end
            T_BEQ:  add(8, rbit(), op);
            T_J:    add(9, rbit(), op);
            T_LW: begin
                add(2, rbit(), op);
                for (int i = 0; i < wm; i++) add(3, 1'b0, op);
                add(3, 1'b1, op);
                add(4, rbit(), op);
            end
            T_SW: begin
                add(2, rbit(), op);
                for (int i = 0; i < wm; i++) add(5, 1'b0, op);
                add(5, 1'b1, op);
            end
            default: begin
`ifdef ILLEGAL_TRAP_EN
                for (int i = 0; i < 5; i++) add(12, rbit(), op);
`endif
            end
        endcase
    endtask

    // Play the plan one cycle at a time; opcode is garbage outside DECODE
    task automatic run_plan();
        step_t s;
        while (plan.size() > 0) begin
            s = plan.pop_front();
            @(negedge clk);
            mem_ready = s.rdy;
            opcode    = (s.st == 4'd1) ? s.op : 6'($urandom);
            #1;
            checks++;
            assert (state_o === s.st) else begin
                errors++;
                $error("FAIL state observed %0d expected %0d", state_o, s.st);
            end
            checks++;
            assert (outs === exp_out(int'(s.st), s.rdy)) else begin
                errors++;
                $error("FAIL outputs st=%0d observed %h expected %h", s.st, outs, exp_out(int'(s.st), s.rdy));
            end
            checks++;
            assert (mem_timeout === tmo_due) else begin
                errors++;
                $error("FAIL mem_timeout st=%0d observed %b expected %b", s.st, mem_timeout, tmo_due);
            end
            if ((s.st == 4'd0 || s.st == 4'd3 || s.st == 4'd5) && !s.rdy) begin
                waits_done++;
                tmo_due = (waits_done == WAIT_LIMIT);
            end else begin
                waits_done = 0;
                tmo_due    = 1'b0;
            end
        end
    endtask

    // One reset cycle: FETCH view with no strobes while asserted, FETCH state and quiet timeout after
    task automatic do_reset(input int cur_st);
        @(negedge clk);
        reset     = 1'b1;
        mem_ready = rbit();
        opcode    = 6'($urandom);
        #1;
        if (cur_st >= 0) begin
            checks++;
            assert (state_o === 4'(cur_st)) else begin
                errors++;
                $error("FAIL state_before_reset observed %0d expected %0d", state_o, cur_st);
            end
        end
        checks++;
        assert (outs === exp_out(0, 1'b0)) else begin
            errors++;
            $error("FAIL reset_outputs observed %h expected %h", outs, exp_out(0, 1'b0));
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        checks++;
        assert (state_o === 4'd0) else begin
            errors++;
            $error("FAIL state_after_reset observed %0d expected 0", state_o);
        end
        checks++;
        assert (mem_timeout === 1'b0) else begin
            errors++;
            $error("FAIL timeout_after_reset observed %b expected 0", mem_timeout);
        end
        waits_done = 0;
        tmo_due    = 1'b0;
    endtask

    logic [5:0] pool [8];

    initial begin
        reset     = 1'b1;
        mem_ready = 1'b0;
        opcode    = 6'b0;
        pool = '{T_R, T_LW, T_SW, T_BEQ, T_J, T_ADDI, 6'h11, 6'h2A};
        repeat (2) @(posedge clk);
        do_reset(-1);

        plan_instr(T_R, 0, 0);
        plan_instr(T_LW, 0, 2);
        plan_instr(T_SW, 0, 0);
        plan_instr(T_BEQ, 0, 0);
        plan_instr(T_J, 0, 0);
        plan_instr(T_ADDI, 16, 0);
        plan_instr(T_LW, 1, 20);
        plan_instr(T_SW, 2, 17);
        run_plan();

        for (int i = 0; i < 40; i++) begin
`ifdef ILLEGAL_TRAP_EN
            plan_instr(pool[$urandom_range(0, 5)], $urandom_range(0, 3), $urandom_range(0, 3));
`else
            plan_instr(pool[$urandom_range(0, 7)], $urandom_range(0, 3), $urandom_range(0, 3));
`endif
            run_plan();
        end

        add(0, 1'b1, T_R);
        add(1, 1'b1, T_R);
        run_plan();
        do_reset(6);
        plan_instr(T_R, 0, 0);
        run_plan();

        add(0, 1'b0, T_LW);
        add(0, 1'b0, T_LW);
        add(0, 1'b0, T_LW);
        run_plan();
        do_reset(0);

`ifdef ILLEGAL_TRAP_EN
        plan_instr(T_BAD, 0, 0);
        run_plan();
        do_reset(12);
`else
        plan_instr(T_BAD, 0, 0);
`endif
        plan_instr(T_ADDI, 0, 0);
        add(0, 1'b1, T_J);
        run_plan();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
